// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (fetch/data) arbiter in front of a synchronous 4-lane ROM, one read outstanding.
// Ports: CLK/RST clock and sync active-high reset; f_* fetch port and d_* data port, each with
// req/addr in, combinational gnt out, and a valid/ready response (data, err); rom_addr/rom_data to the ROM.
module rom_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_data,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_data,
  output logic        d_err,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q;
  logic        owner_q;
  logic        err_q;
  logic [2:0]  starve_q, starve_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic        f_valid_q, d_valid_q, f_err_q, d_err_q;
  logic [31:0] f_data_q, d_data_q;
  logic        f_bad, d_bad, idle_ok, d_win;
  always_comb begin
    f_bad      = (f_addr[1:0] != 2'd0) || (f_addr[31:8] != 24'd0);
    d_bad      = (d_addr[1:0] != 2'd0) || (d_addr[31:8] != 24'd0);
    idle_ok    = (state_q == IDLE) && !RST;
    d_win      = d_req && (!f_req || int'(starve_q) >= STARVE_LIMIT);
    d_gnt      = idle_ok && d_win;
    f_gnt      = idle_ok && f_req && !d_win;
    rom_addr_d = d_gnt ? d_addr[7:2] : f_gnt ? f_addr[7:2] : rom_addr_q;
    starve_d   = d_gnt ? 3'd0 : (f_gnt && d_req && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      starve_q   <= 3'd0;
      rom_addr_q <= 6'd0;
      f_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      f_data_q   <= 32'd0;
      d_data_q   <= 32'd0;
    end else begin
      starve_q   <= starve_d;
      rom_addr_q <= rom_addr_d;
      case (state_q)
        IDLE: if (f_gnt || d_gnt) begin
          owner_q <= d_gnt;
          err_q   <= d_gnt ? d_bad : f_bad;
          state_q <= WAIT;
        end
        WAIT: begin
          f_valid_q <= !owner_q;
          d_valid_q <= owner_q;
          f_err_q   <= !owner_q && err_q;
          d_err_q   <= owner_q && err_q;
          f_data_q  <= owner_q ? f_data_q : err_q ? 32'd0 : rom_data;
          d_data_q  <= owner_q ? (err_q ? 32'd0 : rom_data) : d_data_q;
          state_q   <= RESP;
        end
        RESP: if (owner_q ? d_ready : f_ready) begin
          f_valid_q <= 1'b0;
          d_valid_q <= 1'b0;
          f_err_q   <= 1'b0;
          d_err_q   <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rom_addr = rom_addr_d;
  assign f_valid  = f_valid_q;
  assign d_valid  = d_valid_q;
  assign f_err    = f_err_q;
  assign d_err    = d_err_q;
  assign f_data   = f_data_q;
  assign d_data   = d_data_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized and directed scoreboard bench for rom_arbiter.
module tb_rom_arbiter;
  localparam int LIMIT = 4;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic        f_ready = 1'b1, d_ready = 1'b1;
  logic        f_gnt, d_gnt, f_valid, d_valid, f_err, d_err;
  logic [31:0] f_data, d_data;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] mem [64];
  rom_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_ready(f_ready),
    .f_data(f_data), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid), .d_ready(d_ready),
    .d_data(d_data), .d_err(d_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) rom_data <= mem[rom_addr];
  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          due;
  } item_t;
  item_t q[$];
  int    checks = 0, errors = 0, cyc = 0, rd = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  bit          m_busy = 0, m_own = 0, m_ef, m_ed, m_bad;
  int          m_due = 0, m_cnt = 0;
  logic [31:0] m_a;
  always @(negedge CLK) begin
    m_ef = 0;
    m_ed = 0;
    if (RST) begin
      m_busy = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (f_req || d_req) begin
        m_ed  = d_req && (!f_req || m_cnt >= LIMIT);
        m_ef  = !m_ed;
        m_a   = m_ed ? d_addr : f_addr;
        m_bad = (m_a[1:0] != 0) || (m_a[31:8] != 0);
        q.push_back('{m_ed, m_bad ? 32'd0 : mem[m_a[7:2]], m_bad, cyc + 2});
        chk("rom_addr", {26'd0, rom_addr}, {26'd0, m_a[7:2]});
        m_busy = 1;
        m_own  = m_ed;
        m_due  = cyc + 2;
        m_cnt  = m_ed ? 0 : d_req ? (m_cnt < 7 ? m_cnt + 1 : 7) : m_cnt;
      end
    end else if (cyc >= m_due) begin
      chk("valid_on_time", m_own ? d_valid : f_valid, 1);
      if (m_own ? d_ready : f_ready) m_busy = 0;
    end
    chk("f_gnt", f_gnt, m_ef);
    chk("d_gnt", d_gnt, m_ed);
  end
  item_t mo;
  always @(negedge CLK) begin
    if (RST) rd = q.size();
    else if (f_valid || d_valid) begin
      if (rd >= q.size()) chk("unexpected_valid", {d_valid, f_valid}, 0);
      else begin
        mo = q[rd];
        chk("valid_port", {d_valid, f_valid}, mo.port ? 2 : 1);
        chk("early_valid", cyc >= mo.due, 1);
        chk("resp_data", mo.port ? d_data : f_data, mo.data);
        chk("resp_err", mo.port ? d_err : f_err, mo.err);
        if (mo.port ? d_ready : f_ready) rd++;
      end
    end
  end
  task automatic tick(output bit fg, output bit dg);
    @(negedge CLK);
    fg = f_gnt;
    dg = d_gnt;
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_gnt(input bit dport, output bit ok);
    bit fg, dg;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(fg, dg);
      ok = dport ? dg : fg;
    end
  endtask
  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom % 8;
    return r == 0 ? 32'($urandom) : r == 1 ? 32'($urandom % 256) : 32'(($urandom % 64) * 4);
  endfunction
  bit       fg, dg, ok;
  bit [9:0] order;
  int       n;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'h2002_0005;
    repeat (3) @(posedge CLK);
    #1;
    RST = 0;
    @(negedge CLK);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_f_data", f_data, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_err", {f_err, d_err}, 0);
    chk("rst_rom_addr", {26'd0, rom_addr}, 0);
    @(posedge CLK);
    #1;
    f_req  = 1;
    f_addr = 32'h0000_0010;
    wait_gnt(0, ok);
    chk("single_fetch_gnt", ok, 1);
    f_req = 0;
    repeat (5) tick(fg, dg);
    f_req = 1;
    d_req = 1;
    n = 0;
    order = '0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      f_addr = rnd_addr();
      tick(fg, dg);
      if (fg || dg) begin
        order[n] = dg;
        n++;
      end
    end
    chk("starve_order", order, 10'h210);
    f_req = 0;
    d_req = 0;
    repeat (5) tick(fg, dg);
    d_req   = 1;
    d_addr  = 32'h0000_0020;
    d_ready = 0;
    wait_gnt(1, ok);
    chk("bp_d_gnt", ok, 1);
    d_req  = 0;
    f_req  = 1;
    f_addr = 32'h0000_0030;
    for (int i = 0; i < 6; i++) begin
      tick(fg, dg);
      chk("bp_no_f_gnt", fg, 0);
    end
    d_ready = 1;
    tick(fg, dg);
    chk("bp_no_f_gnt", fg, 0);
    tick(fg, dg);
    chk("bp_f_gnt_after", fg, 1);
    f_req = 0;
    repeat (4) tick(fg, dg);
    f_req  = 1;
    f_addr = 32'h0000_0006;
    wait_gnt(0, ok);
    chk("err_f_gnt", ok, 1);
    f_req = 0;
    repeat (4) tick(fg, dg);
    d_req  = 1;
    d_addr = 32'h0000_0100;
    wait_gnt(1, ok);
    chk("err_d_gnt", ok, 1);
    d_req = 0;
    repeat (4) tick(fg, dg);
    f_req  = 1;
    f_addr = 32'h0000_0010;
    wait_gnt(0, ok);
    chk("midrst_gnt", ok, 1);
    RST    = 1;
    f_addr = 32'h0000_0014;
    tick(fg, dg);
    RST = 0;
    @(negedge CLK);
    chk("midrst_valid", {f_valid, d_valid}, 0);
    chk("midrst_data", f_data | d_data, 0);
    chk("midrst_err", {f_err, d_err}, 0);
    chk("midrst_regrant", f_gnt, 1);
    @(posedge CLK);
    #1;
    f_req = 0;
    repeat (4) tick(fg, dg);
    f_req  = 1;
    d_req  = 1;
    f_addr = 32'h0000_0040;
    d_addr = 32'h0000_0044;
    tick(fg, dg);
    chk("simul_f_wins", {fg, dg}, 2'b10);
    f_req = 0;
    wait_gnt(1, ok);
    chk("simul_d_next", ok, 1);
    d_req = 0;
    repeat (4) tick(fg, dg);
    for (int c = 0; c < 1500; c++) begin
      if (!f_req || fg) begin
        f_req  = ($urandom % 3) != 0;
        f_addr = rnd_addr();
      end
      if (!d_req || dg) begin
        d_req  = ($urandom % 3) != 0;
        d_addr = rnd_addr();
      end
      f_ready = ($urandom % 4) != 0;
      d_ready = ($urandom % 4) != 0;
      RST     = ($urandom % 250) == 0;
      tick(fg, dg);
    end
    RST     = 0;
    f_req   = 0;
    d_req   = 0;
    f_ready = 1;
    d_ready = 1;
    for (int i = 0; i < 20 && rd < q.size(); i++) tick(fg, dg);
    chk("drain", rd, q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
